rdc_window_seq: RTL and testbench
=================================

RDC_WINDOW_SEQ -- requirements
Module: rdc_window_seq

Interface
REQ-001 Parameter W_HEIGHT, default 16: window height in pixels, at least 2.
REQ-002 Parameter W_WIDTH, default 16: window width in pixels, at least 2.
REQ-003 Parameter FLUSH_MAX, default 256: maximum number of pad pixels injected while draining the network.
REQ-004 Derived widths SHALL be V_BITW=ceil(log2(W_HEIGHT)), H_BITW=ceil(log2(W_WIDTH)), N_BITW=ceil(log2(W_HEIGHT*W_WIDTH+1)) and F_BITW=ceil(log2(FLUSH_MAX+1)).
REQ-005 Port clock  in  1  the single clock; all logic is rising-edge.
REQ-006 Port n_rst  in  1  reset, asynchronous and active-low.
REQ-007 Port start  in  1  one-cycle request to process one window.
REQ-008 Port src_valid  in  1  upstream has a pixel available.
REQ-009 Port src_ready  out  1  the sequencer accepts a pixel this cycle.
REQ-010 Port net_enable  out  1  drives the network input enable.
REQ-011 Port net_pad  out  1  the current net_enable beat is a pad (dummy) pixel.
REQ-012 Port net_vcnt  out  V_BITW  window-local row of the beat.
REQ-013 Port net_hcnt  out  H_BITW  window-local column of the beat.
REQ-014 Port net_out_enable  in  1  the network output enable.
REQ-015 Port busy  out  1  high in any state other than IDLE.
REQ-016 Port done  out  1  one-cycle pulse when the window is complete.
REQ-017 Port err  out  1  sticky flush-timeout flag.

Function
REQ-018 The block SHALL implement FSM states IDLE, RUN, DRAIN and DONE, with N=W_HEIGHT*W_WIDTH.
REQ-019 IDLE SHALL go to RUN on start; start SHALL be ignored in every other state.
REQ-020 src_ready SHALL be 1 exactly when the state is RUN.
REQ-021 A transfer is src_valid AND src_ready; each transfer SHALL register net_enable=1 and net_pad=0 on the next cycle, carrying the pre-increment coordinates.
REQ-022 Coordinates SHALL advance in raster order: hcnt wraps at W_WIDTH-1 to 0 and increments vcnt; vcnt wraps at W_HEIGHT-1 to 0.
REQ-023 The N-th transfer SHALL move RUN to DRAIN; src_valid low in RUN SHALL stall without dropping state.
REQ-024 In DRAIN, the block SHALL issue one pad beat per cycle (net_enable=1, net_pad=1), with coordinates continuing the wrapped raster, and SHALL count pad beats.
REQ-025 An output counter SHALL increment on net_out_enable in RUN or DRAIN and SHALL ignore it in IDLE and DONE.
REQ-026 When the output count reaches N, the FSM SHALL go to DONE on the next edge and stop pad injection; a pulse arriving in the same cycle as the N-th transfer is counted.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE, clearing the coordinates and both counters.
REQ-028 Latency SHALL be: start to first src_ready = 1 cycle; transfer to net_enable = 1 cycle.
REQ-029 net_enable SHALL be 0 in IDLE and DONE.

Reset
REQ-030 While n_rst=0, the block SHALL force state IDLE and all counters to 0.
REQ-031 While n_rst=0, outputs SHALL be src_ready=0, net_enable=0, net_pad=0, net_vcnt=0, net_hcnt=0, busy=0, done=0 and err=0.
REQ-032 Reset asserted mid-window SHALL abandon the window without producing a done pulse.

Configuration
REQ-033 With RDC_SEQ_TIMEOUT_EN defined, reaching a pad count of FLUSH_MAX in DRAIN SHALL set err=1 and force DONE; err clears only on reset.
REQ-034 Without RDC_SEQ_TIMEOUT_EN, err SHALL be tied to 0 and DRAIN SHALL wait indefinitely for N outputs.

Structure
REQ-035 Package rdc_pkg SHALL hold the FSM state enum and the ceil-log2 width function.
REQ-036 The raster coordinate counter SHALL be sub-module rdc_raster_cnt (inputs inc and clr; outputs vcnt, hcnt and last).

Verification (W_HEIGHT=4, W_WIDTH=4, FLUSH_MAX=20)
REQ-037 Start with src_valid held at 1 -> 16 beats with net_pad=0; the coordinates run (0,0)..(3,3); DRAIN follows.
REQ-038 src_valid toggled 1/0 -> 16 transfers over 32 cycles; beats are contiguous in raster order and none are lost.
REQ-039 net_out_enable pulsed 16 times, the last 6 cycles into DRAIN -> done pulses exactly once; busy falls the cycle after done.
REQ-040 With the macro defined and net_out_enable held at 0 -> err=1 after 20 pad beats, then DONE.
REQ-041 start asserted during RUN, and n_rst dropped mid-RUN -> the first is ignored; the second gives all outputs 0, and no done occurs.

Source files
------------

// File: rtl/rdc_pkg.sv
// Shared definitions for the window sequencer.
//   state_t : sequencer FSM encoding (IDLE, RUN, DRAIN, DONE)
//   clog2   : ceil(log2(v)), used for the derived counter widths
package rdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rdc_raster_cnt.sv
// Raster coordinate counter for one window.
//   clock, n_rst : rising-edge clock, asynchronous active-low reset
//   inc          : advance one position in raster order
//   clr          : synchronous return to (0,0); wins over inc
//   vcnt, hcnt   : current row / column
//   last         : current position is the final one of the window
module rdc_raster_cnt
  import rdc_pkg::*;
#(
  parameter int unsigned W_HEIGHT = 16,
  parameter int unsigned W_WIDTH  = 16,
  localparam int unsigned V_BITW  = clog2(W_HEIGHT),
  localparam int unsigned H_BITW  = clog2(W_WIDTH)
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              inc,
  input  logic              clr,
  output logic [V_BITW-1:0] vcnt,
  output logic [H_BITW-1:0] hcnt,
  output logic              last
);

  localparam logic [V_BITW-1:0] V_LAST = V_BITW'(W_HEIGHT - 1);
  localparam logic [H_BITW-1:0] H_LAST = H_BITW'(W_WIDTH - 1);

  logic h_wrap;
  logic v_wrap;

  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);
  assign last   = h_wrap & v_wrap;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      vcnt <= '0;
      hcnt <= '0;
    end else if (clr) begin
      vcnt <= '0;
      hcnt <= '0;
    end else if (inc) begin
      if (h_wrap) begin
        hcnt <= '0;
        vcnt <= v_wrap ? '0 : vcnt + V_BITW'(1);
      end else begin
        hcnt <= hcnt + H_BITW'(1);
      end
    end
  end

endmodule

// File: rtl/rdc_window_seq.sv
// Window sequencer: accepts W_HEIGHT*W_WIDTH pixels in raster order, then
// injects pad beats to drain the network until the network has produced
// W_HEIGHT*W_WIDTH outputs.
//   clock, n_rst    : rising-edge clock, asynchronous active-low reset
//   start           : one-cycle request to process one window (IDLE only)
//   src_valid       : upstream pixel available
//   src_ready       : pixel accepted this cycle (state RUN)
//   net_enable      : registered network input enable
//   net_pad         : current beat is a pad pixel
//   net_vcnt/hcnt   : window-local coordinates of the current beat
//   net_out_enable  : network output enable, counted in RUN/DRAIN
//   busy, done, err : not-IDLE, one-cycle completion, sticky flush timeout
// Build option: define RDC_SEQ_TIMEOUT_EN to abort DRAIN after FLUSH_MAX
// pad beats with err set; otherwise err is 0 and DRAIN waits indefinitely.
module rdc_window_seq
  import rdc_pkg::*;
#(
  parameter int unsigned W_HEIGHT  = 16,
  parameter int unsigned W_WIDTH   = 16,
  parameter int unsigned FLUSH_MAX = 256,
  localparam int unsigned V_BITW   = clog2(W_HEIGHT),
  localparam int unsigned H_BITW   = clog2(W_WIDTH),
  localparam int unsigned N_BITW   = clog2(W_HEIGHT * W_WIDTH + 1),
  localparam int unsigned F_BITW   = clog2(FLUSH_MAX + 1)
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              start,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              net_enable,
  output logic              net_pad,
  output logic [V_BITW-1:0] net_vcnt,
  output logic [H_BITW-1:0] net_hcnt,
  input  logic              net_out_enable,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [N_BITW-1:0] N_CNT = N_BITW'(W_HEIGHT * W_WIDTH);
  localparam logic [F_BITW-1:0] F_MAX = F_BITW'(FLUSH_MAX);

  state_t              state;
  state_t              state_nx;
  logic                xfer;
  logic                pad_issue;
  logic                beat;
  logic                timeout;
  logic [V_BITW-1:0]   vcnt;
  logic [H_BITW-1:0]   hcnt;
  logic                last;
  logic [N_BITW-1:0]   out_cnt;
  logic [F_BITW-1:0]   pad_cnt;

  assign src_ready = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign xfer      = src_valid & src_ready;
  assign beat      = xfer | pad_issue;

`ifdef RDC_SEQ_TIMEOUT_EN
  assign timeout = (pad_cnt == F_MAX);
`else
  assign timeout = 1'b0;
`endif

  // The raster position after N-1 transfers is the last one, so the
  // coordinate counter doubles as the input transfer count.
  rdc_raster_cnt #(
    .W_HEIGHT (W_HEIGHT),
    .W_WIDTH  (W_WIDTH)
  ) u_raster (
    .clock (clock),
    .n_rst (n_rst),
    .inc   (beat),
    .clr   (state == DONE),
    .vcnt  (vcnt),
    .hcnt  (hcnt),
    .last  (last)
  );

  always_comb begin
    state_nx  = state;
    pad_issue = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (xfer && last) state_nx = DRAIN;
      DRAIN: begin
        if ((out_cnt == N_CNT) || timeout) state_nx = DONE;
        else                               pad_issue = 1'b1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      net_enable <= 1'b0;
      net_pad    <= 1'b0;
      net_vcnt   <= '0;
      net_hcnt   <= '0;
      out_cnt    <= '0;
      pad_cnt    <= '0;
    end else begin
      state      <= state_nx;
      net_enable <= beat;
      net_pad    <= pad_issue;

      if (beat) begin
        net_vcnt <= vcnt;
        net_hcnt <= hcnt;
      end else if (state == DONE) begin
        net_vcnt <= '0;
        net_hcnt <= '0;
      end

      if (state == DONE)
        out_cnt <= '0;
      else if ((state == RUN || state == DRAIN) && net_out_enable && (out_cnt != N_CNT))
        out_cnt <= out_cnt + N_BITW'(1);

      // Saturates at FLUSH_MAX so an unbounded drain cannot wrap it.
      if (state == DONE)
        pad_cnt <= '0;
      else if (pad_issue && (pad_cnt != F_MAX))
        pad_cnt <= pad_cnt + F_BITW'(1);
    end
  end

`ifdef RDC_SEQ_TIMEOUT_EN
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst)
      err <= 1'b0;
    else if (state == DRAIN && timeout)
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rdc_window_seq.sv
// Directed bench for rdc_window_seq with a 4x4 window and FLUSH_MAX=20.
module tb_rdc_window_seq;

  logic       clock;
  logic       n_rst;
  logic       start;
  logic       src_valid;
  logic       src_ready;
  logic       net_enable;
  logic       net_pad;
  logic [1:0] net_vcnt;
  logic [1:0] net_hcnt;
  logic       net_out_enable;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  rdc_window_seq #(
    .W_HEIGHT  (4),
    .W_WIDTH   (4),
    .FLUSH_MAX (20)
  ) dut (
    .clock          (clock),
    .n_rst          (n_rst),
    .start          (start),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .net_enable     (net_enable),
    .net_pad        (net_pad),
    .net_vcnt       (net_vcnt),
    .net_hcnt       (net_hcnt),
    .net_out_enable (net_out_enable),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, 32'({src_ready, net_enable, net_pad, net_vcnt, net_hcnt, busy, done, err}), 32'd0);
  endtask

  int pads;
  int dones;
  int limit;

  initial begin
    n_rst          = 1'b1;
    start          = 1'b0;
    src_valid      = 1'b0;
    net_out_enable = 1'b0;
    #2 n_rst = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    n_rst = 1'b1;
    step();
    chk_all_zero("idle");

    // Window 1: src_valid held high, 16 contiguous data beats.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("a_ready", 32'(src_ready), 32'd1);
    chk("a_busy", 32'(busy), 32'd1);
    chk("a_en0", 32'(net_enable), 32'd0);
    src_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("a_en", 32'(net_enable), 32'd1);
      chk("a_pad", 32'(net_pad), 32'd0);
      chk("a_v", 32'(net_vcnt), 32'(i / 4));
      chk("a_h", 32'(net_hcnt), 32'(i % 4));
    end
    src_valid = 1'b0;
    chk("a_drain_ready", 32'(src_ready), 32'd0);
    step();
    chk("a_pad0", 32'({net_enable, net_pad, net_vcnt, net_hcnt}), 32'b11_00_00);
    step();
    chk("a_pad1", 32'({net_enable, net_pad, net_vcnt, net_hcnt}), 32'b11_00_01);
    net_out_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("a_nodone", 32'(done), 32'd0);
    end
    net_out_enable = 1'b0;
    step();
    chk("a_done", 32'({done, busy, net_enable}), 32'b110);
    step();
    chk("a_idle", 32'({done, busy, net_enable, net_vcnt, net_hcnt}), 32'd0);

    // Window 2: src_valid toggled, 10 outputs in RUN then 6 in DRAIN.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 31; i++) begin
      src_valid      = (i % 2 == 0);
      net_out_enable = (i < 10);
      step();
      if (i % 2 == 0) begin
        chk("b_en", 32'(net_enable), 32'd1);
        chk("b_pad", 32'(net_pad), 32'd0);
        chk("b_v", 32'(net_vcnt), 32'(i / 8));
        chk("b_h", 32'(net_hcnt), 32'((i / 2) % 4));
      end else begin
        chk("b_gap", 32'(net_enable), 32'd0);
      end
    end
    src_valid      = 1'b0;
    net_out_enable = 1'b0;
    step();
    chk("b_pad0", 32'({net_enable, net_pad, net_vcnt, net_hcnt}), 32'b11_00_00);
    chk("b_ready", 32'(src_ready), 32'd0);
    net_out_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("b_nodone", 32'(done), 32'd0);
    end
    net_out_enable = 1'b0;
    dones = 0;
    step();
    chk("b_done", 32'({done, busy}), 32'b11);
    step();
    chk("b_busy_fall", 32'({done, busy}), 32'b00);
    for (int i = 0; i < 5; i++) begin
      step();
      if (done) dones++;
    end
    chk("b_done_once", 32'(dones), 32'd0);

    // Window 3: start during RUN ignored, reset mid-RUN abandons.
    start = 1'b1;
    step();
    start = 1'b0;
    src_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("c_beat3", 32'({net_enable, net_pad, net_vcnt, net_hcnt}), 32'b10_00_11);
    chk("c_run", 32'({src_ready, busy}), 32'b11);
    src_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    chk_all_zero("c_rst");
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) dones++;
    end
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) dones++;
    end
    chk("c_nodone", 32'(dones), 32'd0);
    chk_all_zero("c_after");

    // Window 4: no network outputs during DRAIN.
    start = 1'b1;
    step();
    start = 1'b0;
    src_valid = 1'b1;
    for (int i = 0; i < 16; i++) step();
    src_valid = 1'b0;
    pads = 0;
`ifdef RDC_SEQ_TIMEOUT_EN
    limit = 0;
    while (!done && limit < 40) begin
      step();
      if (net_enable && net_pad) pads++;
      limit++;
    end
    chk("d_done_seen", 32'(done), 32'd1);
    chk("d_pads", 32'(pads), 32'd20);
    chk("d_err", 32'(err), 32'd1);
    step();
    chk("d_err_sticky", 32'({err, busy}), 32'b10);
    n_rst = 1'b0;
    #1;
    chk("d_err_clr", 32'(err), 32'd0);
    n_rst = 1'b1;
    step();
`else
    for (int i = 0; i < 40; i++) begin
      step();
      if (net_enable && net_pad) pads++;
    end
    chk("d_pads", 32'(pads), 32'd40);
    chk("d_still_drain", 32'({busy, done, err, src_ready}), 32'b1000);
    net_out_enable = 1'b1;
    for (int i = 0; i < 16; i++) step();
    net_out_enable = 1'b0;
    step();
    chk("d_done", 32'({done, err}), 32'b10);
    step();
    chk("d_idle", 32'(busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
